// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel active-low LED pattern generator (off/on/blink/breathe)
module led_pattern_gen #(
    parameter int CLK_HZ   = 12_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int CHANNELS = 3,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [3:0]          wr_ch,
    input  logic [1:0]          wr_mode,
    input  logic [15:0]         wr_period,
    output logic                tick,
    output logic [CHANNELS-1:0] nLED
);
    localparam int PRESC = CLK_HZ / TICK_HZ;
    localparam int PW = $clog2(PRESC);
    localparam logic [PW-1:0] PLAST = PW'(PRESC - 1);
    localparam logic [PWM_BITS-1:0] DMAX = '1;
    logic [PW-1:0]       pcnt;
    logic [PWM_BITS-1:0] pwm;
    // tick prescaler: one-cycle pulse after the counter reaches its last value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else begin
            tick <= pcnt == PLAST;
            pcnt <= pcnt == PLAST ? '0 : pcnt + 1'b1;
        end
    end
    // shared free-running PWM frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm <= '0;
        else pwm <= pwm + 1'b1;
    end
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [1:0]          mode;
        logic [15:0]         period, cnt, last;
        logic                phase, dir, hit, stp, lit, nled_r;
        logic [PWM_BITS-1:0] duty;
        // write decode, step detection and lit decision for this channel
        always_comb begin
            hit  = wr_en && wr_ch == 4'(i);
            last = period == 16'd0 ? 16'd0 : period - 16'd1;
            stp  = tick && mode[1] && cnt >= last;
            lit  = mode == 2'd1 ? 1'b1 : mode == 2'd2 ? phase : mode == 2'd3 ? pwm < duty : 1'b0;
        end
        // channel state: a write wins over a coincident tick
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mode   <= 2'd0;
                period <= 16'd1;
                cnt    <= 16'd0;
                phase  <= 1'b0;
                duty   <= '0;
                dir    <= 1'b0;
                nled_r <= 1'b1;
            end else begin
                nled_r <= ~lit;
                if (hit) begin
                    mode   <= wr_mode;
                    period <= wr_period;
                    cnt    <= 16'd0;
                    phase  <= 1'b0;
                    duty   <= '0;
                    dir    <= 1'b0;
                end else if (tick && mode[1]) begin
                    cnt <= stp ? 16'd0 : cnt + 16'd1;
                    if (stp && mode == 2'd2) phase <= ~phase;
                    if (stp && mode == 2'd3) begin
                        duty <= dir ? duty - 1'b1 : duty + 1'b1;
                        if (!dir && duty == DMAX - 1'b1) dir <= 1'b1;
                        if (dir && duty == PWM_BITS'(1)) dir <= 1'b0;
                    end
                end
            end
        end
        assign nLED[i] = nled_r;
    end
endmodule
